proc_controller: RTL and testbench
==================================

// Module: proc_controller
// PURPOSE
//   Fetch/decode/execute controller for the simple 16-bit processor. Holds the PC and
//   instruction register (IR). Sequences instruction fetch, data-memory access and
//   register-file writes. Drives the 3-bit select of the 16-bit 8-to-1 ALU result mux
//   directly downstream.
// PARAMETERS
//   PC_W   7   program-counter width; instruction-memory depth is 2**PC_W
//   D_AW   8   data-memory address width (equals IR field [11:4] / [7:0])
// PORTS
//   clk         in   1      system clock, all state updates on rising edge
//   rst_n       in   1      synchronous, active-low reset
//   instr_in    in   16     instruction-memory read data (async ROM, valid for current pc_addr)
//   pc_addr     out  PC_W   instruction-memory address = PC register
//   ir_out      out  16     IR contents (debug)
//   d_addr      out  D_AW   data-memory address
//   d_rd        out  1      data-memory read strobe
//   d_wr        out  1      data-memory write strobe
//   rf_ra_addr  out  4      RF read port A address = IR[11:8], always
//   rf_rb_addr  out  4      RF read port B address = IR[7:4], always
//   rf_w_addr   out  4      RF write address = IR[3:0], always
//   rf_w_en     out  1      RF write enable
//   rf_s        out  1      RF write-data select: 1 = data memory, 0 = ALU mux output
//   alu_sel     out  3      ALU mux select: 0 = pass A, 1 = A+B, 2 = A-B (3..7 unused)
//   state_out   out  4      current state encoding (debug)
//   halted      out  1      high while in HALT
// BEHAVIOUR
// - Clock and reset: one clock, clk. Reset rst_n is synchronous and active-low: sampled
//   on clk rise, at any time, including mid-instruction. It forces state = INIT, PC = 0
//   and IR = 16'h0000.
// - Output timing: all strobes are Moore outputs decoded from state (and IR), with no
//   added latency.
// - Default values: in INIT and after reset, d_rd = d_wr = rf_w_en = rf_s = 0,
//   alu_sel = 0, halted = 0, d_addr = 0.
// - Opcode IR[15:12]: 0 NOOP, 1 STORE, 2 LOAD, 3 ADD, 4 SUB, 5 HALT. Values 6..15 are
//   executed as NOOP.
// - INIT: -> FETCH.
// - FETCH: IR <= instr_in; PC <= PC+1, wrapping from 2**PC_W-1 to 0. -> DECODE.
// - DECODE: branch on opcode to NOOP / STORE / LOAD_A / ADD / SUB / HALT.
// - NOOP: no strobes. -> FETCH.
// - LOAD_A: d_addr = IR[11:4], d_rd = 1. -> LOAD_B.
// - LOAD_B: d_addr = IR[11:4], d_rd = 1, rf_s = 1, rf_w_en = 1. -> FETCH.
// - STORE: d_addr = IR[7:0], d_wr = 1 (data = RF port A). -> FETCH.
// - ADD: alu_sel = 1, rf_s = 0, rf_w_en = 1. -> FETCH.
// - SUB: alu_sel = 2, rf_s = 0, rf_w_en = 1. -> FETCH.
// - HALT: halted = 1, all strobes 0; PC and IR frozen. Stays in HALT until rst_n = 0.
// - Instruction cost: NOOP, STORE, ADD, SUB take 3 cycles from FETCH to FETCH.
//   LOAD takes 4.
// - At most one of d_rd, d_wr is high in any cycle.
// - rf_w_en is high only in LOAD_B, ADD and SUB.
// STRUCTURE
// - Shared package proc_pkg: opcode_t enum (NOOP..HALT), state_t enum (4-bit), and
//   ALU_PASS = 3'd0, ALU_ADD = 3'd1, ALU_SUB = 3'd2.
// - One sub-module, pc_counter (PC_W): synchronous clear, increment enable, wrap.
// - The FSM and IR register live in proc_controller.
// TESTING
// - Reset: hold rst_n = 0 for 2 clks -> state_out = INIT, pc_addr = 0, all strobes 0;
//   release -> FETCH next clk.
// - LOAD 16'h2A13: d_addr = 8'hA1, d_rd high in 2 consecutive cycles; rf_w_en & rf_s
//   high only in the 2nd; rf_w_addr = 3; 4 cycles total.
// - ADD 16'h3125 then SUB 16'h4125: ra = 1, rb = 2, w = 5; alu_sel = 1 then 2 in the
//   execute cycle; rf_w_en = 1, rf_s = 0.
// - STORE 16'h1734: d_addr = 8'h34, d_wr = 1 for one cycle, rf_ra_addr = 7, rf_w_en = 0.
// - HALT 16'h5000: halted = 1 and pc_addr frozen for 20 clks; rst_n = 0 -> INIT,
//   pc_addr = 0.
// - Edge cases:
//   - Opcode 16'hF000 behaves as NOOP (3 cycles, no strobes).
//   - PC at 127 fetches, then wraps to 0.
//   - rst_n = 0 during LOAD_A -> INIT next clk with no rf_w_en.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared types for the 16-bit processor controller: opcodes, FSM states and
// the ALU result-mux select codes.
package proc_pkg;

    typedef enum logic [3:0] {
        OP_NOOP  = 4'd0,
        OP_STORE = 4'd1,
        OP_LOAD  = 4'd2,
        OP_ADD   = 4'd3,
        OP_SUB   = 4'd4,
        OP_HALT  = 4'd5
    } opcode_t;

    typedef enum logic [3:0] {
        ST_INIT   = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_NOOP   = 4'd3,
        ST_STORE  = 4'd4,
        ST_LOAD_A = 4'd5,
        ST_LOAD_B = 4'd6,
        ST_ADD    = 4'd7,
        ST_SUB    = 4'd8,
        ST_HALT   = 4'd9
    } state_t;

    localparam logic [2:0] ALU_PASS = 3'd0;
    localparam logic [2:0] ALU_ADD  = 3'd1;
    localparam logic [2:0] ALU_SUB  = 3'd2;

endpackage

// File: rtl/pc_counter.sv
// Program counter: synchronous active-low clear, increment enable, natural
// wrap at 2**PC_W.
module pc_counter #(
    parameter int unsigned PC_W = 7
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            inc_i,
    output logic [PC_W-1:0] pc_o
);

    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (inc_i) begin
            pc_d = pc_q + {{(PC_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/proc_controller.sv
// Fetch/decode/execute controller: owns the IR and the FSM, drives memory,
// register-file and ALU-mux controls as Moore outputs of state and IR.
module proc_controller
    import proc_pkg::*;
#(
    parameter int unsigned PC_W = 7,
    parameter int unsigned D_AW = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [15:0]     instr_in,
    output logic [PC_W-1:0] pc_addr,
    output logic [15:0]     ir_out,
    output logic [D_AW-1:0] d_addr,
    output logic            d_rd,
    output logic            d_wr,
    output logic [3:0]      rf_ra_addr,
    output logic [3:0]      rf_rb_addr,
    output logic [3:0]      rf_w_addr,
    output logic            rf_w_en,
    output logic            rf_s,
    output logic [2:0]      alu_sel,
    output logic [3:0]      state_out,
    output logic            halted
);

    state_t      state_q, state_d;
    logic [15:0] ir_q, ir_d;

    pc_counter #(
        .PC_W(PC_W)
    ) u_pc (
        .clk_i (clk),
        .rst_ni(rst_n),
        .inc_i (state_q == ST_FETCH),
        .pc_o  (pc_addr)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_INIT;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    always_comb begin
        ir_d    = ir_q;
        state_d = state_q;
        case (state_q)
            ST_INIT:   state_d = ST_FETCH;
            ST_FETCH: begin
                ir_d    = instr_in;
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                // Unassigned opcodes fall through to NOOP.
                case (ir_q[15:12])
                    OP_STORE: state_d = ST_STORE;
                    OP_LOAD:  state_d = ST_LOAD_A;
                    OP_ADD:   state_d = ST_ADD;
                    OP_SUB:   state_d = ST_SUB;
                    OP_HALT:  state_d = ST_HALT;
                    default:  state_d = ST_NOOP;
                endcase
            end
            ST_LOAD_A: state_d = ST_LOAD_B;
            ST_HALT:   state_d = ST_HALT;
            default:   state_d = ST_FETCH;
        endcase
    end

    always_comb begin
        d_addr  = '0;
        d_rd    = 1'b0;
        d_wr    = 1'b0;
        rf_w_en = 1'b0;
        rf_s    = 1'b0;
        alu_sel = ALU_PASS;
        halted  = 1'b0;
        case (state_q)
            ST_LOAD_A: begin
                d_addr = D_AW'(ir_q[11:4]);
                d_rd   = 1'b1;
            end
            ST_LOAD_B: begin
                d_addr  = D_AW'(ir_q[11:4]);
                d_rd    = 1'b1;
                rf_s    = 1'b1;
                rf_w_en = 1'b1;
            end
            ST_STORE: begin
                d_addr = D_AW'(ir_q[7:0]);
                d_wr   = 1'b1;
            end
            ST_ADD: begin
                alu_sel = ALU_ADD;
                rf_w_en = 1'b1;
            end
            ST_SUB: begin
                alu_sel = ALU_SUB;
                rf_w_en = 1'b1;
            end
            ST_HALT:  halted = 1'b1;
            default: ;
        endcase
    end

    assign ir_out     = ir_q;
    assign rf_ra_addr = ir_q[11:8];
    assign rf_rb_addr = ir_q[7:4];
    assign rf_w_addr  = ir_q[3:0];
    assign state_out  = state_q;

endmodule

// File: tb/tb_proc_controller.sv
// Scoreboard bench for proc_controller: a program-level model predicts every
// strobe cycle; a negedge monitor pops and compares whenever a strobe appears.
module tb_proc_controller;
    import proc_pkg::*;

    localparam int DEPTH = 128;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] instr_in;
    logic [6:0]  pc_addr;
    logic [15:0] ir_out;
    logic [7:0]  d_addr;
    logic        d_rd, d_wr, rf_w_en, rf_s, halted;
    logic [3:0]  rf_ra_addr, rf_rb_addr, rf_w_addr, state_out;
    logic [2:0]  alu_sel;

    logic [15:0] rom [DEPTH];

    proc_controller #(
        .PC_W(7),
        .D_AW(8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .instr_in  (instr_in),
        .pc_addr   (pc_addr),
        .ir_out    (ir_out),
        .d_addr    (d_addr),
        .d_rd      (d_rd),
        .d_wr      (d_wr),
        .rf_ra_addr(rf_ra_addr),
        .rf_rb_addr(rf_rb_addr),
        .rf_w_addr (rf_w_addr),
        .rf_w_en   (rf_w_en),
        .rf_s      (rf_s),
        .alu_sel   (alu_sel),
        .state_out (state_out),
        .halted    (halted)
    );

    always #5 clk = ~clk;
    assign instr_in = rom[pc_addr];

    typedef struct packed {
        logic       rd, wr, wen, rfs;
        logic [2:0] alu;
        logic [7:0] daddr;
        logic [3:0] ra, rb, wa;
        logic [6:0] pc;
        logic [15:0] ir;
        logic       halt;
    } obs_t;

    typedef struct {
        int unsigned cyc;
        obs_t        o;
    } exp_t;

    exp_t        sbq[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int unsigned cyc = 0;
    logic        halt_prev = 1'b0;
    obs_t        act;
    exp_t        e;

    task automatic push_exp(input int unsigned c, input logic rd, input logic wr,
                            input logic wen, input logic rfs, input logic [2:0] alu,
                            input logic [7:0] daddr, input logic [15:0] w,
                            input logic [6:0] pc, input logic halt);
        exp_t x;
        x.cyc = c;
        x.o   = '{rd: rd, wr: wr, wen: wen, rfs: rfs, alu: alu, daddr: daddr,
                  ra: w[11:8], rb: w[7:4], wa: w[3:0], pc: pc, ir: w, halt: halt};
        sbq.push_back(x);
    endtask

    // Walk the program from PC 0: first fetch is observed cycle 2 (cycle 1 is INIT).
    task automatic build_model(input int unsigned limit);
        int unsigned pc = 0;
        int unsigned t = 2;
        logic [15:0] w;
        logic [6:0]  npc;
        bit          done = 0;
        while (!done && t <= limit) begin
            w   = rom[pc];
            npc = 7'((pc + 1) % DEPTH);
            case (w[15:12])
                4'd1: begin
                    if (t + 2 <= limit) push_exp(t + 2, 0, 1, 0, 0, 3'd0, w[7:0], w, npc, 0);
                    t += 3;
                end
                4'd2: begin
                    if (t + 2 <= limit) push_exp(t + 2, 1, 0, 0, 0, 3'd0, w[11:4], w, npc, 0);
                    if (t + 3 <= limit) push_exp(t + 3, 1, 0, 1, 1, 3'd0, w[11:4], w, npc, 0);
                    t += 4;
                end
                4'd3: begin
                    if (t + 2 <= limit) push_exp(t + 2, 0, 0, 1, 0, 3'd1, 8'h00, w, npc, 0);
                    t += 3;
                end
                4'd4: begin
                    if (t + 2 <= limit) push_exp(t + 2, 0, 0, 1, 0, 3'd2, 8'h00, w, npc, 0);
                    t += 3;
                end
                4'd5: begin
                    if (t + 2 <= limit) push_exp(t + 2, 0, 0, 0, 0, 3'd0, 8'h00, w, npc, 1);
                    done = 1;
                end
                default: t += 3;
            endcase
            pc = npc;
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            cyc       = 0;
            halt_prev = 1'b0;
        end else begin
            cyc++;
            n_cmp++;
            if (d_rd && d_wr) begin
                n_err++;
                $display("FAIL rd_wr_exclusive cyc=%0d: d_rd=%b d_wr=%b, required not both", cyc, d_rd, d_wr);
            end
            if (d_rd || d_wr || rf_w_en || (halted && !halt_prev)) begin
                act = '{rd: d_rd, wr: d_wr, wen: rf_w_en, rfs: rf_s, alu: alu_sel,
                        daddr: d_addr, ra: rf_ra_addr, rb: rf_rb_addr, wa: rf_w_addr,
                        pc: pc_addr, ir: ir_out, halt: halted};
                n_cmp++;
                if (sbq.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_output cyc=%0d: got %h, required no output", cyc, act);
                end else begin
                    e = sbq.pop_front();
                    if (e.cyc != cyc || e.o !== act) begin
                        n_err++;
                        $display("FAIL output cyc=%0d: got %h, required %h at cyc=%0d", cyc, act, e.o, e.cyc);
                    end
                end
            end
            halt_prev = halted;
        end
    end

    task automatic chk(input string name, input logic [31:0] a, input logic [31:0] x);
        n_cmp++;
        if (a !== x) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, a, x);
        end
    endtask

    // Caller is just past a posedge; reset held for two clocks, then released.
    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", 32'(state_out), 32'(ST_INIT));
        chk("rst_pc", 32'(pc_addr), 0);
        chk("rst_ir", 32'(ir_out), 0);
        chk("rst_strobes", {d_rd, d_wr, rf_w_en, rf_s, halted}, 0);
        chk("rst_alu_daddr", {alu_sel, d_addr}, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("release_fetch", 32'(state_out), 32'(ST_FETCH));
        chk("release_pc", 32'(pc_addr), 0);
    endtask

    task automatic check_drained(input string name);
        chk(name, sbq.size(), 0);
        sbq.delete();
    endtask

    initial begin
        logic [31:0] r;
        logic [3:0]  op;
        bit          hit;

        foreach (rom[i]) rom[i] = 16'h0000;
        rom[0] = 16'h2A13;
        rom[1] = 16'h3125;
        rom[2] = 16'h4125;
        rom[3] = 16'h1734;
        rom[4] = 16'hF000;
        rom[5] = 16'h5000;
        build_model(200);
        @(posedge clk);
        #1;
        do_reset();
        hit = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (halted) begin
                hit = 1;
                break;
            end
        end
        chk("halt_reached", 32'(hit), 1);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            chk("halt_frozen", {halted, ir_out, 1'b0, pc_addr}, {1'b1, 16'h5000, 8'd6});
        end
        check_drained("directed_drained");

        foreach (rom[i]) rom[i] = 16'h0000;
        rom[0] = 16'h2A13;
        do_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("load_a_strobes", {state_out, d_rd, rf_w_en, d_addr}, {ST_LOAD_A, 1'b1, 1'b0, 8'hA1});
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midload_reset", {state_out, d_rd, rf_w_en, 1'b0, pc_addr}, {ST_INIT, 2'b00, 8'd0});

        for (int ph = 0; ph < 2; ph++) begin
            foreach (rom[i]) begin
                r  = $urandom();
                op = r[15:12];
                if (op == 4'd5 && (ph == 0 || r[16])) op = (ph == 0) ? 4'd3 : 4'd0;
                rom[i] = {op, r[11:0]};
            end
            if (ph == 0) begin
                r = $urandom();
                rom[DEPTH-1] = {4'd3, r[11:0]};
            end
            build_model(700);
            do_reset();
            hit = 0;
            for (int i = 0; i < 1000; i++) begin
                @(posedge clk);
                if (cyc >= 700) begin
                    hit = 1;
                    break;
                end
            end
            #1;
            chk("random_budget", 32'(hit), 1);
            check_drained("random_drained");
            rst_n = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
